// File: rtl/mem_stage_pkg.sv
// Memory stage encodings shared by the M-stage FSM and the lane aligner.
// RegWrite, ResultSrc and MemWrite codes plus the data-access FSM states.
package mem_stage_pkg;

  localparam logic [2:0] RW_NONE = 3'b000;
  localparam logic [2:0] RW_WORD = 3'b001;
  localparam logic [2:0] RW_LB   = 3'b010;
  localparam logic [2:0] RW_LH   = 3'b011;
  localparam logic [2:0] RW_LBU  = 3'b100;
  localparam logic [2:0] RW_LHU  = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SB   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SW   = 2'b11;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension
// and misalignment detection for the memory stage.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [1:0]  memWrite,
  input  logic [2:0]  regWrite,
  input  logic        isLoad,
  input  logic [31:0] storeData,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] loadData,
  output logic        misalign
);

  logic [7:0]  lb;
  logic [15:0] lh;
  logic        isHalf;
  logic        isWord;

  always_comb begin
    be    = 4'b1111;
    wdata = storeData;
    unique case (1'b1)
      memWrite == MW_SB: begin
        be    = 4'b0001 << addrLo;
        wdata = {4{storeData[7:0]}};
      end
      memWrite == MW_SH: begin
        be    = addrLo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{storeData[15:0]}};
      end
      default: ;
    endcase
  end

  assign lb = rdata[{addrLo, 3'b000} +: 8];
  assign lh = addrLo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    loadData = rdata;
    unique case (1'b1)
      regWrite == RW_LB:  loadData = {{24{lb[7]}}, lb};
      regWrite == RW_LH:  loadData = {{16{lh[15]}}, lh};
      regWrite == RW_LBU: loadData = {24'h0, lb};
      regWrite == RW_LHU: loadData = {16'h0, lh};
      default: ;
    endcase
  end

  assign isHalf = (memWrite == MW_SH)
    || (isLoad && (regWrite == RW_LH || regWrite == RW_LHU));
  assign isWord = (memWrite == MW_SW)
    || (isLoad && regWrite == RW_WORD);
  assign misalign = (isHalf && addrLo[0])
    || (isWord && addrLo != 2'b00);

endmodule

// File: rtl/memory_cycle.sv
// Memory pipeline stage: dmem req/ack handshake with timeout,
// stall generation and the M->W pipeline register.
module memory_cycle
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [1:0]  MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RDM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RDW,
  output logic        misalignW,
  output logic        bus_errW
);

  localparam logic [31:0] TLIM = TIMEOUT_CYCLES - 1;

  state_e      state, stateNext;
  logic [31:0] cnt, cntNext;
  logic        isLoad, access, misalign;
  logic        timeoutHit, latch;
  logic        wLoad, misNext, errNext;
  logic [3:0]  alignBe;
  logic [31:0] alignWdata, loadData;
  logic        reqWe;
  logic [3:0]  reqBe;
  logic [31:0] reqAddr, reqWdata;

  assign isLoad = (ResultSrcM == RS_MEM);
  assign access = (MemWriteM != MW_NONE) || isLoad;
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (cnt == TLIM);

  lsu_align uAlign (
    .addrLo    (ALUResultM[1:0]),
    .memWrite  (MemWriteM),
    .regWrite  (RegWriteM),
    .isLoad    (isLoad),
    .storeData (WriteDataM),
    .rdata     (dmem_rdata),
    .be        (alignBe),
    .wdata     (alignWdata),
    .loadData  (loadData),
    .misalign  (misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      reqWe    <= 1'b0;
      reqBe    <= '0;
      reqAddr  <= '0;
      reqWdata <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (latch) begin
        reqWe    <= (MemWriteM != MW_NONE);
        reqBe    <= alignBe;
        reqAddr  <= {ALUResultM[31:2], 2'b00};
        reqWdata <= alignWdata;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    latch      = 1'b0;
    wLoad      = 1'b0;
    misNext    = 1'b0;
    errNext    = 1'b0;
    StallM     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = '0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    unique case (state)
      IDLE: begin
        cntNext = '0;
        if (!access) begin
          wLoad = 1'b1;
        end else if (misalign) begin
          misNext = 1'b1;
        end else begin
          dmem_req   = 1'b1;
          dmem_we    = (MemWriteM != MW_NONE);
          dmem_be    = alignBe;
          dmem_addr  = {ALUResultM[31:2], 2'b00};
          dmem_wdata = alignWdata;
          if (dmem_ack) begin
            wLoad = 1'b1;
          end else begin
            StallM    = 1'b1;
            latch     = 1'b1;
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        dmem_req   = 1'b1;
        dmem_we    = reqWe;
        dmem_be    = reqBe;
        dmem_addr  = reqAddr;
        dmem_wdata = reqWdata;
        if (dmem_ack) begin
          wLoad     = 1'b1;
          stateNext = IDLE;
        end else if (timeoutHit) begin
          // release the stall so the dropped access leaves M
          errNext   = 1'b1;
          stateNext = IDLE;
        end else begin
          StallM  = 1'b1;
          cntNext = cnt + 32'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (!rst) begin
      dmem_req = 1'b0;
      StallM   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RDW        <= '0;
      misalignW  <= 1'b0;
      bus_errW   <= 1'b0;
    end else begin
      misalignW <= misNext;
      bus_errW  <= errNext;
      if (wLoad) begin
        RegWriteW  <= (RegWriteM != RW_NONE)
          && (MemWriteM == MW_NONE);
        ResultSrcW <= ResultSrcM;
        ALUResultW <= ALUResultM;
        ReadDataW  <= isLoad ? loadData : '0;
        PCPlus4W   <= PCPlus4M;
        RDW        <= RDM;
      end else begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= '0;
        ALUResultW <= '0;
        ReadDataW  <= '0;
        PCPlus4W   <= '0;
        RDW        <= '0;
      end
    end
  end

endmodule
